// File: rtl/lmem_port_arbiter.sv
// ----------------------------------------------------------------------------
// lmem_port_arbiter
//   Shares the single layer-memory port between two masters:
//     master 0 = convolution/pooling engine, master 1 = readback/debug master.
//   Arbitration is round-robin with burst hold, and the grant is combinational
//   in the same cycle. An accepted command drives the memory one cycle later.
//   Read data is routed back to the master that issued the read, together
//   with a per-master valid strobe.
//
// Ports
//   clk, reset                 clock, asynchronous active-high reset
//   reqN/weN/selN/addrN/wdataN master N command (N = 0,1); held until gntN
//   gntN                       command from master N accepted this cycle
//   rvalidN/rdataN             read return to master N (registered)
//   cwr/crd/csel               memory write strobe, read strobe, layer select
//   caddr_wr/caddr_rd          memory write / read address
//   cdata_wr/cdata_rd          memory write data / read data
// ----------------------------------------------------------------------------
module lmem_port_arbiter #(
    parameter int AW        = 12,
    parameter int DW        = 13,
    parameter int RD_LAT    = 1,
    parameter int MAX_BURST = 16
) (
    input  logic          clk,
    input  logic          reset,
    // master 0
    input  logic          req0,
    input  logic          we0,
    input  logic          sel0,
    input  logic [AW-1:0] addr0,
    input  logic [DW-1:0] wdata0,
    output logic          gnt0,
    output logic          rvalid0,
    output logic [DW-1:0] rdata0,
    // master 1
    input  logic          req1,
    input  logic          we1,
    input  logic          sel1,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata1,
    output logic          gnt1,
    output logic          rvalid1,
    output logic [DW-1:0] rdata1,
    // memory port
    output logic          cwr,
    output logic          crd,
    output logic          csel,
    output logic [AW-1:0] caddr_wr,
    output logic [AW-1:0] caddr_rd,
    output logic [DW-1:0] cdata_wr,
    input  logic [DW-1:0] cdata_rd
);

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_0    = 2'd1,
        OWN_1    = 2'd2
    } owner_e;

    localparam logic [7:0] BURST_MAX = 8'(MAX_BURST);

    // ------------------------------------------------------------------
    // Arbitration state
    // ------------------------------------------------------------------
    owner_e     owner_q, owner_d;
    logic       last_gnt_q, last_gnt_d;   // 1 -> master 0 wins the next tie
    logic [7:0] burst_cnt_q, burst_cnt_d;
    logic       burst_ok;

    // The current owner may keep the port only while below the burst limit,
    // unless the other master is not asking.
    assign burst_ok = (burst_cnt_q < BURST_MAX);

    // NOTE: every output of a combinational block gets a default first;
    // a path that leaves a signal unassigned would infer a latch.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        unique case (owner_q)
            OWN_0: begin
                if (req0 && (burst_ok || !req1)) gnt0 = 1'b1;
                else if (req1)                   gnt1 = 1'b1;
            end
            OWN_1: begin
                if (req1 && (burst_ok || !req0)) gnt1 = 1'b1;
                else if (req0)                   gnt0 = 1'b1;
            end
            default: begin
                if (req0 && req1) begin
                    if (last_gnt_q) gnt0 = 1'b1;
                    else            gnt1 = 1'b1;
                end else begin
                    gnt0 = req0;
                    gnt1 = req1;
                end
            end
        endcase
    end

    always_comb begin
        owner_d     = OWN_NONE;
        last_gnt_d  = last_gnt_q;
        burst_cnt_d = '0;
        if (gnt0) begin
            owner_d     = OWN_0;
            last_gnt_d  = 1'b0;
            // Saturates: burst_ok is false once the limit is reached.
            burst_cnt_d = (owner_q == OWN_0) ?
                          (burst_ok ? burst_cnt_q + 8'd1 : burst_cnt_q) : 8'd1;
        end else if (gnt1) begin
            owner_d     = OWN_1;
            last_gnt_d  = 1'b1;
            burst_cnt_d = (owner_q == OWN_1) ?
                          (burst_ok ? burst_cnt_q + 8'd1 : burst_cnt_q) : 8'd1;
        end
    end

    // NOTE: sequential state is updated with non-blocking assignments only,
    // so every register samples the pre-edge values regardless of ordering.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            owner_q     <= OWN_NONE;
            last_gnt_q  <= 1'b1;
            burst_cnt_q <= '0;
        end else begin
            owner_q     <= owner_d;
            last_gnt_q  <= last_gnt_d;
            burst_cnt_q <= burst_cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // Command issue (one cycle after grant)
    // ------------------------------------------------------------------
    logic          cmd_gnt, cmd_we, cmd_sel;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata;

    assign cmd_gnt   = gnt0 | gnt1;
    assign cmd_we    = gnt1 ? we1    : we0;
    assign cmd_sel   = gnt1 ? sel1   : sel0;
    assign cmd_addr  = gnt1 ? addr1  : addr0;
    assign cmd_wdata = gnt1 ? wdata1 : wdata0;

    logic          cwr_q, crd_q, csel_q;
    logic [AW-1:0] caddr_wr_q, caddr_rd_q;
    logic [DW-1:0] cdata_wr_q;
    logic          rd_id_q;               // master that issued the current command

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cwr_q      <= 1'b0;
            crd_q      <= 1'b0;
            csel_q     <= 1'b0;
            caddr_wr_q <= '0;
            caddr_rd_q <= '0;
            cdata_wr_q <= '0;
            rd_id_q    <= 1'b0;
        end else begin
            // Strobes are mutually exclusive by construction.
            cwr_q <= cmd_gnt &  cmd_we;
            crd_q <= cmd_gnt & ~cmd_we;
            // Address, data and select hold between commands.
            if (cmd_gnt) begin
                csel_q  <= cmd_sel;
                rd_id_q <= gnt1;
                if (cmd_we) begin
                    caddr_wr_q <= cmd_addr;
                    cdata_wr_q <= cmd_wdata;
                end else begin
                    caddr_rd_q <= cmd_addr;
                end
            end
        end
    end

    assign cwr      = cwr_q;
    assign crd      = crd_q;
    assign csel     = csel_q;
    assign caddr_wr = caddr_wr_q;
    assign caddr_rd = caddr_rd_q;
    assign cdata_wr = cdata_wr_q;

    // ------------------------------------------------------------------
    // Read-tag pipe: stage RD_LAT-1 lines up with cdata_rd for that read.
    // A single shift pipe keeps return order equal to issue order.
    // ------------------------------------------------------------------
    logic [RD_LAT-1:0] pipe_vld_q, pipe_id_q;

    // NOTE: the tag pipe is reset so that reads in flight at reset are
    // dropped and never raise rvalid afterwards.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pipe_vld_q <= '0;
            pipe_id_q  <= '0;
        end else begin
            pipe_vld_q[0] <= crd_q;
            pipe_id_q[0]  <= rd_id_q;
            for (int i = 1; i < RD_LAT; i++) begin
                pipe_vld_q[i] <= pipe_vld_q[i-1];
                pipe_id_q[i]  <= pipe_id_q[i-1];
            end
        end
    end

    logic ret_vld, ret_id;
    assign ret_vld = pipe_vld_q[RD_LAT-1];
    assign ret_id  = pipe_id_q[RD_LAT-1];

    logic          rvalid0_q, rvalid1_q;
    logic [DW-1:0] rdata0_q, rdata1_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
            rdata0_q  <= '0;
            rdata1_q  <= '0;
        end else begin
            rvalid0_q <= ret_vld & ~ret_id;
            rvalid1_q <= ret_vld &  ret_id;
            if (ret_vld && !ret_id) rdata0_q <= cdata_rd;
            if (ret_vld &&  ret_id) rdata1_q <= cdata_rd;
        end
    end

    assign rvalid0 = rvalid0_q;
    assign rvalid1 = rvalid1_q;
    assign rdata0  = rdata0_q;
    assign rdata1  = rdata1_q;

endmodule

// File: tb/tb_lmem_port_arbiter.sv
// ----------------------------------------------------------------------------
// tb_lmem_port_arbiter
//   Directed bench for lmem_port_arbiter (AW=12, DW=13, RD_LAT=1,
//   MAX_BURST=16). A small memory model returns mem[caddr_rd] one cycle after
//   crd. Inputs change 1 time unit after the rising edge; outputs are sampled
//   on the falling edge.
// ----------------------------------------------------------------------------
module tb_lmem_port_arbiter;

    localparam int AW = 12;
    localparam int DW = 13;

    logic          clk = 1'b0;
    logic          reset;
    logic          req0, we0, sel0, req1, we1, sel1;
    logic [AW-1:0] addr0, addr1;
    logic [DW-1:0] wdata0, wdata1;
    logic          gnt0, gnt1, rvalid0, rvalid1;
    logic [DW-1:0] rdata0, rdata1;
    logic          cwr, crd, csel;
    logic [AW-1:0] caddr_wr, caddr_rd;
    logic [DW-1:0] cdata_wr;
    logic [DW-1:0] cdata_rd = '0;

    logic [DW-1:0] mem [0:(1<<AW)-1];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    lmem_port_arbiter #(
        .AW(AW), .DW(DW), .RD_LAT(1), .MAX_BURST(16)
    ) dut (
        .clk(clk), .reset(reset),
        .req0(req0), .we0(we0), .sel0(sel0), .addr0(addr0), .wdata0(wdata0),
        .gnt0(gnt0), .rvalid0(rvalid0), .rdata0(rdata0),
        .req1(req1), .we1(we1), .sel1(sel1), .addr1(addr1), .wdata1(wdata1),
        .gnt1(gnt1), .rvalid1(rvalid1), .rdata1(rdata1),
        .cwr(cwr), .crd(crd), .csel(csel),
        .caddr_wr(caddr_wr), .caddr_rd(caddr_rd),
        .cdata_wr(cdata_wr), .cdata_rd(cdata_rd)
    );

    // Memory model: one-cycle read latency.
    always @(posedge clk) begin
        if (crd) cdata_rd <= mem[caddr_rd];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".gnt"},    {30'd0, gnt0, gnt1}, 32'd0);
        check({tag, ".strobe"}, {30'd0, cwr, crd}, 32'd0);
        check({tag, ".csel"},   {31'd0, csel}, 32'd0);
        check({tag, ".caddr_wr"}, {20'd0, caddr_wr}, 32'd0);
        check({tag, ".caddr_rd"}, {20'd0, caddr_rd}, 32'd0);
        check({tag, ".cdata_wr"}, {19'd0, cdata_wr}, 32'd0);
        check({tag, ".rvalid"}, {30'd0, rvalid0, rvalid1}, 32'd0);
        check({tag, ".rdata0"}, {19'd0, rdata0}, 32'd0);
        check({tag, ".rdata1"}, {19'd0, rdata1}, 32'd0);
    endtask

    initial begin
        for (int i = 0; i < (1 << AW); i++) mem[i] = '0;
        mem[12'h041] = 13'h0150;
        mem[12'h000] = 13'h0AAA;
        mem[12'h001] = 13'h1234;

        reset = 1'b1;
        req0 = 0; we0 = 0; sel0 = 0; addr0 = '0; wdata0 = '0;
        req1 = 0; we1 = 0; sel1 = 0; addr1 = '0; wdata1 = '0;

        // ---------------- reset state ----------------
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_all_zero("reset");
        step();
        reset = 1'b0;
        step();

        // ---------------- single read ----------------
        req0 = 1; we0 = 0; sel0 = 0; addr0 = 12'h041;
        @(negedge clk);
        check("rd.gnt0", {31'd0, gnt0}, 32'd1);
        check("rd.gnt1", {31'd0, gnt1}, 32'd0);
        step();
        req0 = 0;
        @(negedge clk);
        check("rd.crd", {31'd0, crd}, 32'd1);
        check("rd.cwr", {31'd0, cwr}, 32'd0);
        check("rd.caddr_rd", {20'd0, caddr_rd}, 32'h041);
        check("rd.csel", {31'd0, csel}, 32'd0);
        step();
        @(negedge clk);
        check("rd.rvalid0_early", {31'd0, rvalid0}, 32'd0);
        step();
        @(negedge clk);
        check("rd.rvalid0", {31'd0, rvalid0}, 32'd1);
        check("rd.rdata0", {19'd0, rdata0}, 32'h0150);
        check("rd.rvalid1", {31'd0, rvalid1}, 32'd0);
        step();
        @(negedge clk);
        check("rd.rvalid0_drop", {31'd0, rvalid0}, 32'd0);
        check("rd.rdata0_hold", {19'd0, rdata0}, 32'h0150);

        // ---------------- write from master 1 ----------------
        step();
        req1 = 1; we1 = 1; sel1 = 1; addr1 = 12'h3FF; wdata1 = 13'h0090;
        @(negedge clk);
        check("wr.gnt1", {31'd0, gnt1}, 32'd1);
        check("wr.gnt0", {31'd0, gnt0}, 32'd0);
        step();
        req1 = 0; we1 = 0;
        @(negedge clk);
        check("wr.cwr", {31'd0, cwr}, 32'd1);
        check("wr.crd", {31'd0, crd}, 32'd0);
        check("wr.csel", {31'd0, csel}, 32'd1);
        check("wr.caddr_wr", {20'd0, caddr_wr}, 32'h3FF);
        check("wr.cdata_wr", {19'd0, cdata_wr}, 32'h0090);
        check("wr.caddr_rd_hold", {20'd0, caddr_rd}, 32'h041);

        // ---------------- idle ----------------
        for (int i = 0; i < 10; i++) begin
            step();
            @(negedge clk);
            check("idle.gnt", {30'd0, gnt0, gnt1}, 32'd0);
            check("idle.strobe", {30'd0, cwr, crd}, 32'd0);
        end
        check("idle.caddr_wr", {20'd0, caddr_wr}, 32'h3FF);
        check("idle.caddr_rd", {20'd0, caddr_rd}, 32'h041);
        check("idle.csel", {31'd0, csel}, 32'd1);

        // ---------------- interleaved reads ----------------
        step();
        req0 = 1; we0 = 0; sel0 = 0; addr0 = 12'h000;
        @(negedge clk);
        check("il.gnt0", {30'd0, gnt0, gnt1}, 32'd2);
        step();
        req0 = 0;
        req1 = 1; we1 = 0; sel1 = 0; addr1 = 12'h001;
        @(negedge clk);
        check("il.gnt1", {30'd0, gnt0, gnt1}, 32'd1);
        check("il.crd_a", {31'd0, crd}, 32'd1);
        check("il.caddr_a", {20'd0, caddr_rd}, 32'h000);
        step();
        req1 = 0;
        @(negedge clk);
        check("il.crd_b", {31'd0, crd}, 32'd1);
        check("il.caddr_b", {20'd0, caddr_rd}, 32'h001);
        step();
        @(negedge clk);
        check("il.rvalid_a", {30'd0, rvalid0, rvalid1}, 32'd2);
        check("il.rdata0", {19'd0, rdata0}, 32'h0AAA);
        step();
        @(negedge clk);
        check("il.rvalid_b", {30'd0, rvalid0, rvalid1}, 32'd1);
        check("il.rdata1", {19'd0, rdata1}, 32'h1234);
        check("il.rdata0_hold", {19'd0, rdata0}, 32'h0AAA);

        // ---------------- reset mid-read ----------------
        step();
        req0 = 1; we0 = 0; sel0 = 0; addr0 = 12'h041;
        @(negedge clk);
        check("rst.gnt0", {31'd0, gnt0}, 32'd1);
        step();
        req0 = 0;
        @(negedge clk);
        check("rst.crd", {31'd0, crd}, 32'd1);
        #2 reset = 1'b1;
        @(negedge clk);
        check_all_zero("rst.in");
        step();
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("rst.no_rvalid", {30'd0, rvalid0, rvalid1}, 32'd0);
            step();
        end

        // ---------------- tie and burst hold ----------------
        reset = 1'b1;
        step();
        reset = 1'b0;
        req0 = 1; we0 = 0; addr0 = 12'h010;
        req1 = 1; we1 = 0; addr1 = 12'h020;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            // 16 grants to master 0, then 16 to master 1, alternating
            if (((i / 16) % 2) == 0)
                check($sformatf("tie.gnt[%0d]", i), {30'd0, gnt0, gnt1}, 32'd2);
            else
                check($sformatf("tie.gnt[%0d]", i), {30'd0, gnt0, gnt1}, 32'd1);
            step();
        end
        req0 = 0;
        req1 = 0;
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
